// File: rtl/imem_fetch_responder.sv
// Instruction-memory fetch responder: sync word RAM, in-order 2-entry response queue, flush.
// Optional write port enabled by defining IMEM_WRITE_PORT_EN (default build is a ROM).
module imem_fetch_responder #(
  parameter int unsigned              ADDR_WIDTH   = 32,
  parameter int unsigned              DATA_WIDTH   = 32,
  parameter int unsigned              DEPTH_WORDS  = 1024,
  parameter logic [ADDR_WIDTH-1:0]    BASE_ADDRESS = '0,
  parameter string                    INIT_FILE    = "",
  parameter logic [DATA_WIDTH-1:0]    NOP_INSTR    = 32'h00000013
) (
  input  logic                  clk,
  input  logic                  a_reset_n,
  input  logic                  flush,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_instr,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic                  rsp_err
`ifdef IMEM_WRITE_PORT_EN
  ,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data
`endif
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH + 1)'(4 * DEPTH_WORDS);

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  initial begin
    for (int unsigned i = 0; i < DEPTH_WORDS; i++) mem[i] = NOP_INSTR;
  end

  // Offset taken one bit wider: an address below the base borrows into the MSB,
  // which then fails the span compare as well, so no separate lower-bound test.
  function automatic logic [ADDR_WIDTH:0] addr_off(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} - {1'b0, BASE_ADDRESS};
  endfunction

  function automatic logic addr_bad(input logic [ADDR_WIDTH-1:0] a);
    return (a[1:0] != 2'b00) || (addr_off(a) >= SPAN);
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
    return IDX_W'(addr_off(a) >> 2);
  endfunction

  logic [1:0]            q_count_q, q_count_d;
  logic                  q_head_q, q_head_d;
  logic [DATA_WIDTH-1:0] q_instr_q [2];
  logic [DATA_WIDTH-1:0] q_instr_d [2];
  logic [ADDR_WIDTH-1:0] q_addr_q [2];
  logic [ADDR_WIDTH-1:0] q_addr_d [2];
  logic [1:0]            q_err_q, q_err_d;

  logic                  inf_valid_q, inf_valid_d;
  logic [ADDR_WIDTH-1:0] inf_addr_q, inf_addr_d;
  logic                  inf_err_q, inf_err_d;
  logic [DATA_WIDTH-1:0] ram_rdata_q;

  logic                  from_q, pop, pop_q, pop_inf, accept, req_err, rd_en;
  logic [1:0]            occ, cnt;
  logic                  head, slot;
  logic [IDX_W-1:0]      rd_idx;
  logic [DATA_WIDTH-1:0] inf_instr;

  // Response head: oldest queued entry, else the read that just completed.
  always_comb begin
    from_q    = (q_count_q != 2'd0);
    inf_instr = inf_err_q ? NOP_INSTR : ram_rdata_q;
    rsp_valid = from_q || inf_valid_q;
    if (!from_q && inf_valid_q) begin
      rsp_instr = inf_instr;
      rsp_addr  = inf_addr_q;
      rsp_err   = inf_err_q;
    end else begin
      rsp_instr = q_instr_q[q_head_q];
      rsp_addr  = q_addr_q[q_head_q];
      rsp_err   = q_err_q[q_head_q];
    end
    pop       = rsp_valid && rsp_ready;
    occ       = q_count_q + {1'b0, inf_valid_q};
    req_ready = a_reset_n && !flush && ((occ - {1'b0, pop}) < 2'd2);
    accept    = req_valid && req_ready;
    req_err   = addr_bad(req_addr);
    rd_idx    = addr_idx(req_addr);
    rd_en     = accept && !req_err;
  end

  always_comb begin
    q_instr_d = q_instr_q;
    q_addr_d  = q_addr_q;
    q_err_d   = q_err_q;
    head      = q_head_q;
    cnt       = q_count_q;
    pop_q     = pop && from_q;
    pop_inf   = pop && !from_q;
    if (pop_q) begin
      head = q_head_q + 1'b1;
      cnt  = q_count_q - 2'd1;
    end
    slot = head + cnt[0];
    if (inf_valid_q && !pop_inf) begin
      q_instr_d[slot] = inf_instr;
      q_addr_d[slot]  = inf_addr_q;
      q_err_d[slot]   = inf_err_q;
      cnt             = cnt + 2'd1;
    end
    q_head_d    = head;
    q_count_d   = flush ? 2'd0 : cnt;
    inf_valid_d = accept;
    inf_addr_d  = req_addr;
    inf_err_d   = req_err;
  end

  always_ff @(posedge clk or negedge a_reset_n) begin
    if (!a_reset_n) begin
      q_count_q   <= '0;
      q_head_q    <= 1'b0;
      q_instr_q   <= '{NOP_INSTR, NOP_INSTR};
      q_addr_q    <= '{'0, '0};
      q_err_q     <= '0;
      inf_valid_q <= 1'b0;
      inf_addr_q  <= '0;
      inf_err_q   <= 1'b0;
    end else begin
      q_count_q   <= q_count_d;
      q_head_q    <= q_head_d;
      q_instr_q   <= q_instr_d;
      q_addr_q    <= q_addr_d;
      q_err_q     <= q_err_d;
      inf_valid_q <= inf_valid_d;
      inf_addr_q  <= inf_addr_d;
      inf_err_q   <= inf_err_d;
    end
  end

  always_ff @(posedge clk) begin
`ifdef IMEM_WRITE_PORT_EN
    if (wr_en && !addr_bad(wr_addr)) mem[addr_idx(wr_addr)] <= wr_data;
`endif
    if (rd_en) ram_rdata_q <= mem[rd_idx];
  end

  a_occ_bound: assert property (@(posedge clk) disable iff (!a_reset_n) occ <= 2'd2);
  a_rsp_hold: assert property (@(posedge clk) disable iff (!a_reset_n)
    (rsp_valid && !rsp_ready && !flush) |=>
      (rsp_valid && $stable(rsp_instr) && $stable(rsp_addr) && $stable(rsp_err)));

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Directed self-checking bench for imem_fetch_responder; memory image preloaded hierarchically.
module tb_imem_fetch_responder;
  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] W0  = 32'h00500093;
  localparam logic [31:0] W1  = 32'h00A00113;
  localparam logic [31:0] W2  = 32'h002081B3;
  localparam logic [31:0] W3  = 32'h40110233;
  localparam logic [31:0] W4  = 32'h00000213;

  logic        clk = 1'b0;
  logic        a_reset_n, flush, req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr, rsp_instr, rsp_addr;
`ifdef IMEM_WRITE_PORT_EN
  logic        wr_en;
  logic [31:0] wr_addr, wr_data;
`endif
  int compared = 0;
  int mismatched = 0;
  int accepted;

  always #5 clk = ~clk;

  imem_fetch_responder #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(1024),
    .BASE_ADDRESS(32'h0), .INIT_FILE(""), .NOP_INSTR(NOP)
  ) dut (
    .clk(clk), .a_reset_n(a_reset_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr),
    .rsp_addr(rsp_addr), .rsp_err(rsp_err)
`ifdef IMEM_WRITE_PORT_EN
    , .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
`endif
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_reset_n = 1'b0; flush = 1'b0; req_valid = 1'b1; req_addr = 32'h0; rsp_ready = 1'b1;
`ifdef IMEM_WRITE_PORT_EN
    wr_en = 1'b0; wr_addr = 32'h0; wr_data = 32'h0;
`endif
    #1;
    dut.mem[0] = W0; dut.mem[1] = W1; dut.mem[2] = W2; dut.mem[3] = W3; dut.mem[4] = W4;
    repeat (3) begin
      cyc();
      compared++; if (rsp_valid !== 1'b0) begin mismatched++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
      compared++; if (req_ready !== 1'b0) begin mismatched++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
    end
    compared++; if (rsp_instr !== NOP) begin mismatched++; $display("FAIL rst_instr: got %h want %h", rsp_instr, NOP); end
    compared++; if (rsp_addr !== 32'h0) begin mismatched++; $display("FAIL rst_addr: got %h want 0", rsp_addr); end
    compared++; if (rsp_err !== 1'b0) begin mismatched++; $display("FAIL rst_err: got %b want 0", rsp_err); end
    req_valid = 1'b0;
    a_reset_n = 1'b1;
    #1;
    compared++; if (req_ready !== 1'b1) begin mismatched++; $display("FAIL post_rst_ready: got %b want 1", req_ready); end
    cyc();
  endtask

  task automatic test_back_to_back();
    rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h0;
    #1;
    compared++; if (req_ready !== 1'b1) begin mismatched++; $display("FAIL b2b_ready0: got %b want 1", req_ready); end
    cyc();
    req_addr = 32'h4;
    #1;
    compared++; if (rsp_valid !== 1'b1) begin mismatched++; $display("FAIL b2b_valid0: got %b want 1", rsp_valid); end
    compared++; if (rsp_instr !== W0) begin mismatched++; $display("FAIL b2b_instr0: got %h want %h", rsp_instr, W0); end
    compared++; if (rsp_addr !== 32'h0) begin mismatched++; $display("FAIL b2b_addr0: got %h want 0", rsp_addr); end
    compared++; if (req_ready !== 1'b1) begin mismatched++; $display("FAIL b2b_ready1: got %b want 1", req_ready); end
    cyc();
    req_valid = 1'b0;
    #1;
    compared++; if (rsp_instr !== W1) begin mismatched++; $display("FAIL b2b_instr1: got %h want %h", rsp_instr, W1); end
    compared++; if (rsp_addr !== 32'h4) begin mismatched++; $display("FAIL b2b_addr1: got %h want 4", rsp_addr); end
    compared++; if (rsp_err !== 1'b0) begin mismatched++; $display("FAIL b2b_err1: got %b want 0", rsp_err); end
    cyc();
    compared++; if (rsp_valid !== 1'b0) begin mismatched++; $display("FAIL b2b_drain: got %b want 0", rsp_valid); end
  endtask

  task automatic test_backpressure();
    logic [31:0] a;
    a = 32'h8; accepted = 0; rsp_ready = 1'b0; req_valid = 1'b1;
    repeat (4) begin
      req_addr = a;
      #1;
      if (req_ready) begin accepted++; a = a + 32'h4; end
      cyc();
    end
    req_valid = 1'b0;
    #1;
    compared++; if (accepted !== 2) begin mismatched++; $display("FAIL bp_accepted: got %0d want 2", accepted); end
    compared++; if (req_ready !== 1'b0) begin mismatched++; $display("FAIL bp_ready_stall: got %b want 0", req_ready); end
    compared++; if (rsp_addr !== 32'h8) begin mismatched++; $display("FAIL bp_hold_addr: got %h want 8", rsp_addr); end
    compared++; if (rsp_instr !== W2) begin mismatched++; $display("FAIL bp_hold_instr: got %h want %h", rsp_instr, W2); end
    rsp_ready = 1'b1;
    cyc();
    compared++; if (rsp_instr !== W3) begin mismatched++; $display("FAIL bp_pop2_instr: got %h want %h", rsp_instr, W3); end
    compared++; if (rsp_addr !== 32'hC) begin mismatched++; $display("FAIL bp_pop2_addr: got %h want c", rsp_addr); end
    cyc();
    compared++; if (rsp_valid !== 1'b0) begin mismatched++; $display("FAIL bp_empty: got %b want 0", rsp_valid); end
    compared++; if (req_ready !== 1'b1) begin mismatched++; $display("FAIL bp_ready_back: got %b want 1", req_ready); end
  endtask

  task automatic test_errors();
    rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h2;
    cyc();
    req_addr = 32'h1000;
    #1;
    compared++; if (rsp_err !== 1'b1) begin mismatched++; $display("FAIL mis_err: got %b want 1", rsp_err); end
    compared++; if (rsp_instr !== NOP) begin mismatched++; $display("FAIL mis_instr: got %h want %h", rsp_instr, NOP); end
    compared++; if (rsp_addr !== 32'h2) begin mismatched++; $display("FAIL mis_addr: got %h want 2", rsp_addr); end
    cyc();
    req_addr = 32'hFFC;
    #1;
    compared++; if (rsp_err !== 1'b1) begin mismatched++; $display("FAIL oor_err: got %b want 1", rsp_err); end
    compared++; if (rsp_instr !== NOP) begin mismatched++; $display("FAIL oor_instr: got %h want %h", rsp_instr, NOP); end
    cyc();
    req_valid = 1'b0;
    #1;
    compared++; if (rsp_err !== 1'b0) begin mismatched++; $display("FAIL last_word_err: got %b want 0", rsp_err); end
    compared++; if (rsp_addr !== 32'hFFC) begin mismatched++; $display("FAIL last_word_addr: got %h want ffc", rsp_addr); end
    cyc();
  endtask

  task automatic test_flush();
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h0;
    cyc();
    req_addr = 32'h4;
    cyc();
    flush = 1'b1; req_addr = 32'hC;
    #1;
    compared++; if (req_ready !== 1'b0) begin mismatched++; $display("FAIL flush_ready: got %b want 0", req_ready); end
    compared++; if (rsp_valid !== 1'b1) begin mismatched++; $display("FAIL flush_full: got %b want 1", rsp_valid); end
    cyc();
    flush = 1'b0; req_addr = 32'h8;
    #1;
    compared++; if (rsp_valid !== 1'b0) begin mismatched++; $display("FAIL flush_cleared: got %b want 0", rsp_valid); end
    compared++; if (req_ready !== 1'b1) begin mismatched++; $display("FAIL flush_ready_back: got %b want 1", req_ready); end
    cyc();
    req_valid = 1'b0; rsp_ready = 1'b1;
    #1;
    compared++; if (rsp_instr !== W2) begin mismatched++; $display("FAIL flush_new_instr: got %h want %h", rsp_instr, W2); end
    compared++; if (rsp_addr !== 32'h8) begin mismatched++; $display("FAIL flush_new_addr: got %h want 8", rsp_addr); end
    cyc();
    compared++; if (rsp_valid !== 1'b0) begin mismatched++; $display("FAIL flush_only_one: got %b want 0", rsp_valid); end
  endtask

  task automatic test_reset_midop();
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h4;
    cyc();
    req_valid = 1'b0; a_reset_n = 1'b0;
    #1;
    compared++; if (rsp_valid !== 1'b0) begin mismatched++; $display("FAIL midrst_valid: got %b want 0", rsp_valid); end
    cyc();
    a_reset_n = 1'b1;
    cyc();
    compared++; if (rsp_valid !== 1'b0) begin mismatched++; $display("FAIL midrst_discard: got %b want 0", rsp_valid); end
  endtask

`ifdef IMEM_WRITE_PORT_EN
  task automatic test_write();
    rsp_ready = 1'b1;
    wr_en = 1'b1; wr_addr = 32'h10; wr_data = 32'hDEADBEEF;
    req_valid = 1'b1; req_addr = 32'h10;
    cyc();
    wr_en = 1'b0;
    #1;
    compared++; if (rsp_instr !== W4) begin mismatched++; $display("FAIL wr_old_data: got %h want %h", rsp_instr, W4); end
    cyc();
    req_valid = 1'b0;
    wr_en = 1'b1; wr_addr = 32'h12; wr_data = 32'h12345678;
    #1;
    compared++; if (rsp_instr !== 32'hDEADBEEF) begin mismatched++; $display("FAIL wr_new_data: got %h want deadbeef", rsp_instr); end
    cyc();
    wr_en = 1'b0; req_valid = 1'b1; req_addr = 32'h10;
    cyc();
    req_valid = 1'b0;
    #1;
    compared++; if (rsp_instr !== 32'hDEADBEEF) begin mismatched++; $display("FAIL wr_misaligned_ignored: got %h want deadbeef", rsp_instr); end
    cyc();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_errors();
    test_flush();
`ifdef IMEM_WRITE_PORT_EN
    test_write();
`endif
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
